// File: rtl/mul_ctrl_pkg.sv
// ---- mul_ctrl_pkg: shared types and latency table for the multiplier scheduler ----
// Rev 1.0
`default_nettype none

package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    SEW_E8   = 2'b00,
    SEW_E16  = 2'b01,
    SEW_E32  = 2'b10,
    SEW_RSVD = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  localparam int c_lat_e8_def  = 2;
  localparam int c_lat_e16_def = 2;
  localparam int c_lat_e32_def = 5;

  function automatic int lat_of(sew_e sew,
                                int   e8  = c_lat_e8_def,
                                int   e16 = c_lat_e16_def,
                                int   e32 = c_lat_e32_def);
    case (sew)
      SEW_E8:  return e8;
      SEW_E16: return e16;
      SEW_E32: return e32;
      default: return 1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---- rr_arbiter: combinational round-robin pick starting at i_ptr ----
// Rev 1.0
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int c_idw = $clog2(NREQ);

  logic w_found;
  int   w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (!w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = c_idw'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_req_scheduler.sv
// ---- mul_req_scheduler: round-robin sharing of one SIMD multiplier among NREQ requesters ----
// Rev 1.0 -- define MUL_HIGH_EN to add req_high (signed high word for e32)
`default_nettype none

module mul_req_scheduler
  import mul_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int LAT_E8  = c_lat_e8_def,
  parameter int LAT_E16 = c_lat_e16_def,
  parameter int LAT_E32 = c_lat_e32_def
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*32-1:0]        req_a,
  input  logic [NREQ*32-1:0]        req_b,
  input  logic [NREQ*2-1:0]         req_sew,
`ifdef MUL_HIGH_EN
  input  logic [NREQ-1:0]           req_high,
`endif
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [63:0]               res_data,
  output logic                      res_err,
  output logic                      mul_start,
  output logic [1:0]                mul_sew,
  output logic [31:0]               mul_a,
  output logic [31:0]               mul_b,
  input  logic [63:0]               mul_product,
  output logic                      busy
);

  localparam int c_idw     = $clog2(NREQ);
  localparam int c_lat_max = (LAT_E32 > LAT_E16) ? ((LAT_E32 > LAT_E8) ? LAT_E32 : LAT_E8)
                                                 : ((LAT_E16 > LAT_E8) ? LAT_E16 : LAT_E8);
  localparam int c_cnt_w   = $clog2(c_lat_max + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [c_idw-1:0]   r_ptr;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  sew_e               r_sew;
  logic [c_idw-1:0]   r_id;
  logic [c_cnt_w-1:0] r_cnt;
  logic [63:0]        r_data;
  logic               r_err;

  logic [NREQ-1:0]    w_grant;
  logic [c_idw-1:0]   w_idx;
  logic               w_accept;
  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  sew_e               w_sel_sew;
  logic [c_idw-1:0]   w_ptr_nxt;
  logic [63:0]        w_capture;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_accept  = (r_state == ST_IDLE) && (|req_valid);
  assign w_sel_a   = req_a[int'(w_idx)*32 +: 32];
  assign w_sel_b   = req_b[int'(w_idx)*32 +: 32];
  assign w_sel_sew = sew_e'(req_sew[int'(w_idx)*2 +: 2]);
  assign w_ptr_nxt = (w_idx == c_idw'(NREQ - 1)) ? '0 : w_idx + c_idw'(1);

`ifdef MUL_HIGH_EN
  logic r_high;
  assign w_capture = (r_high && r_sew == SEW_E32) ? {{32{mul_product[63]}}, mul_product[63:32]}
                                                  : mul_product;
`else
  assign w_capture = mul_product;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    mul_start   = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = w_grant;
        if (w_accept)
          w_state_nxt = (w_sel_sew == SEW_RSVD) ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        mul_start   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand registers only change on accept, so the multiplier sees stable inputs for the whole op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sew  <= SEW_E8;
      r_id   <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
`ifdef MUL_HIGH_EN
      r_high <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a    <= w_sel_a;
        r_b    <= w_sel_b;
        r_sew  <= w_sel_sew;
        r_id   <= w_idx;
        r_ptr  <= w_ptr_nxt;
        r_err  <= (w_sel_sew == SEW_RSVD);
        r_data <= '0;
`ifdef MUL_HIGH_EN
        r_high <= req_high[w_idx];
`endif
      end
      if (r_state == ST_ISSUE)
        r_cnt <= c_cnt_w'(lat_of(r_sew, LAT_E8, LAT_E16, LAT_E32) - 1);
      else if (r_state == ST_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - c_cnt_w'(1);
      if (r_state == ST_WAIT && r_cnt == '0)
        r_data <= w_capture;
    end
  end

  assign mul_a    = r_a;
  assign mul_b    = r_b;
  assign mul_sew  = r_sew;
  assign res_id   = r_id;
  assign res_data = r_data;
  assign res_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mul_req_scheduler.sv
// ---- tb_mul_req_scheduler: timeline reference model plus behavioural SIMD multiplier ----
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_mul_req_scheduler;

  localparam int NREQ    = 2;
  localparam int LAT_E8  = 2;
  localparam int LAT_E16 = 2;
  localparam int LAT_E32 = 5;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*32-1:0]      req_a = '0;
  logic [NREQ*32-1:0]      req_b = '0;
  logic [NREQ*2-1:0]       req_sew = '0;
`ifdef MUL_HIGH_EN
  logic [NREQ-1:0]         req_high = '0;
`endif
  logic                    res_valid;
  logic                    res_ready = 1'b0;
  logic [$clog2(NREQ)-1:0] res_id;
  logic [63:0]             res_data;
  logic                    res_err;
  logic                    mul_start;
  logic [1:0]              mul_sew;
  logic [31:0]             mul_a;
  logic [31:0]             mul_b;
  logic [63:0]             mul_product;
  logic                    busy;

  mul_req_scheduler #(
    .NREQ(NREQ), .LAT_E8(LAT_E8), .LAT_E16(LAT_E16), .LAT_E32(LAT_E32)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sew(req_sew),
`ifdef MUL_HIGH_EN
    .req_high(req_high),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .res_err(res_err),
    .mul_start(mul_start), .mul_sew(mul_sew), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int lat_tb(input logic [1:0] s);
    case (s)
      2'd0:    return LAT_E8;
      2'd1:    return LAT_E16;
      2'd2:    return LAT_E32;
      default: return 1;
    endcase
  endfunction

  // Signed packed multiply: e8 -> four 16-bit products, e16 -> two 32-bit, e32 -> one 64-bit.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
    logic [63:0]        r;
    logic signed [15:0] p8;
    logic signed [31:0] p16;
    logic signed [63:0] p32;
    r = '0;
    case (s)
      2'd0: for (int i = 0; i < 4; i++) begin
        p8 = $signed(a[8*i +: 8]) * $signed(b[8*i +: 8]);
        r[16*i +: 16] = p8;
      end
      2'd1: for (int i = 0; i < 2; i++) begin
        p16 = $signed(a[16*i +: 16]) * $signed(b[16*i +: 16]);
        r[32*i +: 32] = p16;
      end
      2'd2: begin
        p32 = $signed(a) * $signed(b);
        r = p32;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] exp_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] s, input bit h);
    logic [63:0] p;
    p = ref_mul(a, b, s);
    if (s == 2'd2 && h) return {{32{p[63]}}, p[63:32]};
    return p;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Behavioural multiplier: product is only valid in the LAT-th cycle after mul_start.
  logic [63:0] mp_val = '0;
  int          mp_age = 0;
  int          mp_lat = 1;
  always @(posedge clk) begin
    if (!reset) mp_age <= 0;
    else if (mul_start) begin
      mp_val <= ref_mul(mul_a, mul_b, mul_sew);
      mp_lat <= lat_tb(mul_sew);
      mp_age <= 1;
    end else if (mp_age != 0 && mp_age < 100) mp_age <= mp_age + 1;
  end
  assign mul_product = (mp_age != 0 && mp_age == mp_lat) ? mp_val : 64'hBAD0_5EED_BAD0_5EED;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model state (timeline of the current operation).
  bit          m_act = 0;
  int          m_T = 0;
  bit          m_rsvd = 0;
  int          m_lat = 1;
  int          m_id = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [1:0]  m_sew = '0;
  bit          m_high = 0;
  int          m_ptr = 0;

  logic [NREQ-1:0] va = '0;
  logic [31:0]     oa [NREQ];
  logic [31:0]     ob [NREQ];
  logic [1:0]      os [NREQ];
  bit              oh [NREQ];

  logic [63:0] last_data = '0;
  int          last_id = 0;
  bit          last_err = 0;
  int          last_lat = 0;
  bit          acc_flag = 0;
  int          acc_id = 0;
  bit          lit_en = 0;
  logic [63:0] lit_val = '0;

  task automatic step(input bit rr);
    int              g;
    bit              exp_rv;
    logic [NREQ-1:0] exp_rdy;
    res_ready = rr;
    req_valid = va;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32] = oa[i];
      req_b[i*32 +: 32] = ob[i];
      req_sew[i*2 +: 2] = os[i];
`ifdef MUL_HIGH_EN
      req_high[i] = oh[i];
`endif
    end
    #1;
    g = m_act ? -1 : rr_pick(va, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = m_act && (cyc >= m_T + (m_rsvd ? 1 : 2 + m_lat));
    check("req_ready", req_ready, exp_rdy);
    check("busy", busy, m_act);
    check("mul_start", mul_start, m_act && !m_rsvd && (cyc == m_T + 1));
    check("res_valid", res_valid, exp_rv);
    check("mul_a", mul_a, m_a);
    check("mul_b", mul_b, m_b);
    check("mul_sew", mul_sew, m_sew);
    if (exp_rv) begin
      check("res_id", res_id, m_id);
      check("res_data", res_data, m_rsvd ? 64'd0 : exp_res(m_a, m_b, m_sew, m_high));
      check("res_err", res_err, m_rsvd);
      if (rr) begin
        last_data = res_data;
        last_id   = res_id;
        last_err  = res_err;
        last_lat  = cyc - m_T;
        if (lit_en) check("lit_data", res_data, lit_val);
      end
    end
    acc_flag = 0;
    @(posedge clk);
    if (exp_rv && rr) m_act = 0;
    else if (g >= 0) begin
      m_act  = 1;
      m_T    = cyc;
      m_id   = g;
      m_a    = oa[g];
      m_b    = ob[g];
      m_sew  = os[g];
      m_rsvd = (os[g] == 2'd3);
      m_lat  = lat_tb(os[g]);
`ifdef MUL_HIGH_EN
      m_high = oh[g];
`else
      m_high = 0;
`endif
      m_ptr    = (g + 1) % NREQ;
      va[g]    = 1'b0;
      acc_flag = 1;
      acc_id   = g;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    va        = '0;
    req_valid = '0;
    res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_err", res_err, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_mul_sew", mul_sew, 0);
    check("rst_req_ready", req_ready, 0);
    m_act = 0; m_ptr = 0; m_a = '0; m_b = '0; m_sew = '0;
    reset = 1'b1;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((m_act || va != '0) && n < maxc) begin
      step(1'b1);
      n++;
    end
    check("drain_done", (m_act || va != '0), 0);
  endtask

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] s, input bit h);
    oa[i] = a; ob[i] = b; os[i] = s; oh[i] = h; va[i] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    for (int i = 0; i < NREQ; i++) begin
      oa[i] = '0; ob[i] = '0; os[i] = '0; oh[i] = 0;
    end
    do_reset();

    // Single e32 request: -6 at T+7
    load(0, 32'h0000_0003, 32'hFFFF_FFFE, 2'd2, 0);
    drain(40);
    check("t1_data", last_data, 64'hFFFF_FFFF_FFFF_FFFA);
    check("t1_id", last_id, 0);
    check("t1_lat", last_lat, 7);

    // Both requesters always valid, e8: grants alternate from a fresh pointer
    do_reset();
    lit_en = 1; lit_val = 64'h0006_0006_0006_0006;
    for (int i = 0; i < NREQ; i++) load(i, 32'h0202_0202, 32'h0303_0303, 2'd0, 0);
    k = 0; n = 0;
    while (k < 4 && n < 200) begin
      step(1'b1);
      n++;
      if (acc_flag) begin
        check("t2_grant", acc_id, k % 2);
        k++;
        if (k <= 2) va[acc_id] = 1'b1;
      end
    end
    check("t2_count", k, 4);
    drain(40);
    lit_en = 0;

    // Consumer stalls 10 cycles in RESP while requester 1 waits
    load(0, $urandom, $urandom, 2'd1, 0);
    n = 0;
    while (!(m_act && cyc >= m_T + 2 + m_lat) && n < 50) begin
      step(1'b0);
      n++;
      if (n == 2) load(1, $urandom, $urandom, 2'd2, 0);
    end
    repeat (10) step(1'b0);
    step(1'b1);
    check("t3_no_bypass", acc_flag, 0);
    step(1'b1);
    check("t3_accept_next", acc_flag, 1);
    check("t3_accept_id", acc_id, 1);
    drain(40);

    // Reserved sew, then a normal request
    load(0, 32'h1234_5678, 32'h9ABC_DEF0, 2'd3, 0);
    drain(20);
    check("t4_err", last_err, 1);
    check("t4_data", last_data, 0);
    check("t4_lat", last_lat, 1);
    load(1, 32'h0000_0007, 32'h0000_0009, 2'd1, 0);
    drain(20);
    check("t4_next_data", last_data, 64'h0000_0000_0000_003F);
    check("t4_next_err", last_err, 0);

    // Reset during WAIT abandons the op
    load(0, $urandom, $urandom, 2'd2, 0);
    n = 0;
    while (!(m_act && cyc == m_T + 3) && n < 20) begin
      step(1'b1);
      n++;
    end
    do_reset();
    repeat (8) step(1'b1);

`ifdef MUL_HIGH_EN
    load(0, 32'h8000_0000, 32'h0000_0002, 2'd2, 1);
    drain(40);
    check("t6_high", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!va[i] && $urandom_range(0, 2) == 0)
          load(i, $urandom, $urandom,
               ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
               bit'($urandom_range(0, 1)));
      end
      step($urandom_range(0, 3) != 0);
    end
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
